// File: rtl/arith_pkg.sv
// Shared arithmetic constants and types for the serial arithmetic blocks.
package arith_pkg;

  localparam int ARITH_W    = 8;
  localparam int SADD_CNT_W = $clog2(ARITH_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sadd_state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder; the only arithmetic in the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/eightbit_serial_adder.sv
// Bit-serial 8-bit two's-complement adder, one bit per clock, result 8 cycles after start.
// Optional EIGHTBIT_SERIAL_ADDER_SUB_EN adds a 'sub' port selecting A - B.
module eightbit_serial_adder
  import arith_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ARITH_W-1:0] A,
  input  logic [ARITH_W-1:0] B,
`ifdef EIGHTBIT_SERIAL_ADDER_SUB_EN
  input  logic               sub,
`endif
  output logic [ARITH_W-1:0] sum,
  output logic               cout,
  output logic               overflow,
  output logic               busy,
  output logic               done
);

  localparam logic [SADD_CNT_W-1:0] LAST_BIT = SADD_CNT_W'(ARITH_W - 1);

  sadd_state_t             state_q, state_d;
  logic [ARITH_W-1:0]      a_sr_q, a_sr_d;
  logic [ARITH_W-1:0]      b_sr_q, b_sr_d;
  logic [ARITH_W-1:0]      r_sr_q, r_sr_d;
  logic                    carry_q, carry_d;
  logic [SADD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ARITH_W-1:0]      sum_q, sum_d;
  logic                    cout_q, cout_d;
  logic                    ovf_q, ovf_d;

  logic                    fa_s, fa_co;
  logic                    c7_in;
  logic [ARITH_W-1:0]      b_load;
  logic                    cin_load;

`ifdef EIGHTBIT_SERIAL_ADDER_SUB_EN
  // Subtraction is A + ~B + 1: invert B and preset the carry.
  assign b_load   = sub ? ~B : B;
  assign cin_load = sub;
`else
  assign b_load   = B;
  assign cin_load = 1'b0;
`endif

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // On the last bit the carry register holds the carry into the sign bit.
  assign c7_in = carry_q;

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_sr_d  = A;
          b_sr_d  = b_load;
          r_sr_d  = '0;
          carry_d = cin_load;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sr_d  = {1'b0, a_sr_q[ARITH_W-1:1]};
        b_sr_d  = {1'b0, b_sr_q[ARITH_W-1:1]};
        r_sr_d  = {fa_s, r_sr_q[ARITH_W-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          sum_d   = {fa_s, r_sr_q[ARITH_W-1:1]};
          cout_d  = fa_co;
          ovf_d   = c7_in ^ fa_co;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_eightbit_serial_adder.sv
// Directed-vector bench for eightbit_serial_adder: latency, results, handshake and reset abort.
module tb_eightbit_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] A, B;
`ifdef EIGHTBIT_SERIAL_ADDER_SUB_EN
  logic       sub;
`endif
  logic [7:0] sum;
  logic       cout, overflow, busy, done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  eightbit_serial_adder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
`ifdef EIGHTBIT_SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles from the current sample point until done, bounded; returns 99 on timeout.
  task automatic wait_done(output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic sb, input logic [7:0] es, input logic ec, input logic eo);
    int n;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
`ifdef EIGHTBIT_SERIAL_ADDER_SUB_EN
    sub = sb;
`else
    if (sb) $display("note: sub vector issued without subtract support");
`endif
    @(posedge clk); #1;
    start = 1'b0; A = 8'hxx; B = 8'hxx;
    check({tag, ".busy"}, busy, 1);
    wait_done(n);
    check({tag, ".lat"}, n, 8);
    check({tag, ".sum"}, sum, es);
    check({tag, ".cout"}, cout, ec);
    check({tag, ".ovf"}, overflow, eo);
    check({tag, ".busy_at_done"}, busy, 0);
  endtask

  initial begin
    int n, unstable, extra;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
`ifdef EIGHTBIT_SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst.sum", sum, 0);
    check("rst.flags", {cout, overflow, busy, done}, 4'b0000);

    // Reset wins over start on the same edge.
    @(negedge clk); start = 1'b1; A = 8'h11; B = 8'h22;
    @(posedge clk); #1;
    check("rst_vs_start.busy", busy, 0);
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    run_op("add_36_0f", 8'h36, 8'h0F, 1'b0, 8'h45, 1'b0, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Start pulsed mid-RUN is ignored and not queued.
    @(negedge clk); A = 8'h12; B = 8'h34; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); start = 1'b1; A = 8'h01; B = 8'h01;
    @(negedge clk); start = 1'b0;
    wait_done(n);
    check("midrun.lat_total", n, 4);
    check("midrun.sum", sum, 8'h46);
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    check("midrun.not_queued", extra, 0);

    // Back-to-back with start held through DONE.
    @(negedge clk); A = 8'h55; B = 8'h2A; start = 1'b1;
    @(posedge clk); #1;
    A = 8'hC0; B = 8'hC0;
    wait_done(n);
    check("b2b.first_lat", n, 8);
    check("b2b.first_sum", {cout, overflow, sum}, {2'b00, 8'h7F});
    @(negedge clk); start = 1'b1;
    unstable = 0;
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      if (done) begin
        n = i;
        break;
      end
      if (sum !== 8'h7F || cout !== 1'b0 || overflow !== 1'b0) unstable++;
      if (busy && done) unstable++;
    end
    check("b2b.period", n, 9);
    check("b2b.held_outputs", unstable, 0);
    check("b2b.second_sum", {cout, overflow, sum}, {2'b10, 8'h80});

    // Reset during RUN aborts with no done.
    @(negedge clk); A = 8'h7F; B = 8'h7F; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort.sum", sum, 0);
    check("abort.flags", {cout, overflow, busy, done}, 4'b0000);
    @(negedge clk); rst_n = 1'b1;
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    check("abort.no_done", extra, 0);
    run_op("add_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

`ifdef EIGHTBIT_SERIAL_ADDER_SUB_EN
    run_op("sub_36_0f", 8'h36, 8'h0F, 1'b1, 8'h27, 1'b1, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op("sub_7f_ff", 8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
